// File: rtl/asic_gpio_ctrl_pkg.sv
// Shared encodings and helpers for the GPIO control slice.
package asic_gpio_ctrl_pkg;

  localparam int unsigned CFG_W = 8;

  localparam logic [1:0] IRQ_RISE  = 2'b00;
  localparam logic [1:0] IRQ_FALL  = 2'b01;
  localparam logic [1:0] IRQ_BOTH  = 2'b10;
  localparam logic [1:0] IRQ_LEVEL = 2'b11;

  // Pick the event that the pin's interrupt mode listens to.
  function automatic logic sel_event(input logic [1:0] mode, input logic rise,
                                     input logic fall, input logic level);
    logic ev;
    ev = 1'b0;
    case (mode)
      IRQ_RISE:  ev = rise;
      IRQ_FALL:  ev = fall;
      IRQ_BOTH:  ev = rise | fall;
      IRQ_LEVEL: ev = level;
      default:   ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/asic_gpio_ctrl_filter.sv
// One pin's input conditioning: synchroniser, glitch filter, edge history, event decode.
module asic_gpio_ctrl_filter
  import asic_gpio_ctrl_pkg::*;
#(
  parameter int unsigned SYNCSTAGES = 2,
  parameter int unsigned FILT_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ie,
  input  logic       filt_en,
  input  logic       din,
  input  logic [1:0] irq_mode,
  output logic       in_val,
  output logic       evt
);

  localparam int unsigned CntW = (FILT_CYC > 2) ? $clog2(FILT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYC - 1);

  logic [SYNCSTAGES-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  val_q;
  logic                  prev_q;
  logic                  s;
  logic                  rise;
  logic                  fall;

  assign s = sync_q[SYNCSTAGES-1];

  // Sync chain, filter counter and edge history; a disabled receiver pins everything to 0.
  always_ff @(posedge clk) begin
    if (reset || !ie) begin
      sync_q <= '0;
      cnt_q  <= '0;
      val_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNCSTAGES-2:0], din};
      prev_q <= val_q;
      if (!filt_en) begin
        // Unfiltered path also clears the counter, so toggling filt_en mid-count is safe.
        val_q <= s;
        cnt_q <= '0;
      end else if (s == val_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        val_q <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Event decode from the conditioned value and its one-cycle history.
  always_comb begin
    rise = val_q & ~prev_q;
    fall = ~val_q & prev_q;
    evt  = sel_event(irq_mode, rise, fall, val_q);
  end

  assign in_val = val_q;

endmodule

// File: rtl/asic_gpio_ctrl.sv
// GPIO control stage: pad-side registers, per-pin input conditioning, sticky interrupts.
module asic_gpio_ctrl
  import asic_gpio_ctrl_pkg::*;
#(
  parameter int unsigned    N          = 8,
  parameter int unsigned    SYNCSTAGES = 2,
  parameter int unsigned    FILT_CYC   = 4,
  parameter logic [CFG_W-1:0] CFG_RESET = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       out_val,
  input  logic [N-1:0]       out_en,
  input  logic [N-1:0]       in_en,
  input  logic [N-1:0]       filt_en,
  input  logic [CFG_W*N-1:0] cfg_in,
  input  logic [N-1:0]       irq_en,
  input  logic [2*N-1:0]     irq_mode,
  input  logic [N-1:0]       irq_clr,
  input  logic [N-1:0]       din,
  output logic [N-1:0]       dout,
  output logic [N-1:0]       oen,
  output logic [N-1:0]       ie,
  output logic [CFG_W*N-1:0] cfg,
  output logic [N-1:0]       in_val,
  output logic [N-1:0]       irq_status,
  output logic               irq
);

  logic [N-1:0] evt;
  logic [N-1:0] irq_status_d;

  // Pad-side registers toward the iobuf; reset leaves every pad tristated.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
      oen  <= '1;
      ie   <= '0;
      cfg  <= {N{CFG_RESET}};
    end else begin
      dout <= out_val;
      oen  <= ~out_en;
      ie   <= in_en;
      cfg  <= cfg_in;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pin
    asic_gpio_ctrl_filter #(
      .SYNCSTAGES(SYNCSTAGES),
      .FILT_CYC  (FILT_CYC)
    ) u_filter (
      .clk     (clk),
      .reset   (reset),
      .ie      (ie[i]),
      .filt_en (filt_en[i]),
      .din     (din[i]),
      .irq_mode(irq_mode[2*i +: 2]),
      .in_val  (in_val[i]),
      .evt     (evt[i])
    );
  end

  // Sticky status: a new event beats a same-cycle clear.
  always_comb begin
    irq_status_d = (irq_status & ~irq_clr) | (evt & irq_en);
  end

  // Status and its OR-reduce update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= irq_status_d;
      irq        <= |irq_status_d;
    end
  end

endmodule

// File: tb/tb_asic_gpio_ctrl.sv
// Directed self-checking bench for asic_gpio_ctrl (N=8, SYNCSTAGES=2, FILT_CYC=4).
module tb_asic_gpio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  out_val, out_en, in_en, filt_en, irq_en, irq_clr, din;
  logic [63:0] cfg_in;
  logic [15:0] irq_mode;
  logic [7:0]  dout, oen, ie, in_val, irq_status;
  logic [63:0] cfg;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  asic_gpio_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .out_val   (out_val),
    .out_en    (out_en),
    .in_en     (in_en),
    .filt_en   (filt_en),
    .cfg_in    (cfg_in),
    .irq_en    (irq_en),
    .irq_mode  (irq_mode),
    .irq_clr   (irq_clr),
    .din       (din),
    .dout      (dout),
    .oen       (oen),
    .ie        (ie),
    .cfg       (cfg),
    .in_val    (in_val),
    .irq_status(irq_status),
    .irq       (irq)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; out_val = 8'hFF; out_en = 8'hFF; in_en = 8'hFF; filt_en = 8'h00;
    cfg_in = 64'hFFFF_FFFF_FFFF_FFFF; irq_en = 8'h00; irq_mode = 16'h0000;
    irq_clr = 8'h00; din = 8'hFF;
    tick(2);
    checks++; if (oen !== 8'hFF) begin failures++; $display("FAIL reset_oen got=%h exp=ff", oen); end
    checks++; if (ie !== 8'h00) begin failures++; $display("FAIL reset_ie got=%h exp=00", ie); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (cfg !== 64'h0) begin failures++; $display("FAIL reset_cfg got=%h exp=0", cfg); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (in_val !== 8'h00) begin failures++; $display("FAIL reset_in_val got=%h exp=00", in_val); end
    checks++; if (irq_status !== 8'h00) begin failures++; $display("FAIL reset_status got=%h exp=00", irq_status); end
    out_val = 8'h00; out_en = 8'h00; in_en = 8'h00; din = 8'h00; cfg_in = 64'h0;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_drive;
    out_en = 8'h08; out_val = 8'h08; in_en = 8'h5A; cfg_in = 64'h0123_4567_89AB_CDEF;
    tick(1);
    checks++; if (oen !== 8'hF7) begin failures++; $display("FAIL drive_oen got=%h exp=f7", oen); end
    checks++; if (dout !== 8'h08) begin failures++; $display("FAIL drive_dout got=%h exp=08", dout); end
    checks++; if (ie !== 8'h5A) begin failures++; $display("FAIL drive_ie got=%h exp=5a", ie); end
    checks++;
    if (cfg !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("FAIL drive_cfg got=%h exp=0123456789abcdef", cfg);
    end
  endtask

  task automatic test_sync_latency;
    in_en = 8'hFF;
    tick(3);
    din[0] = 1'b1;
    tick(2);
    checks++; if (in_val[0] !== 1'b0) begin failures++; $display("FAIL sync_early got=%b exp=0", in_val[0]); end
    tick(1);
    checks++; if (in_val[0] !== 1'b1) begin failures++; $display("FAIL sync_at3 got=%b exp=1", in_val[0]); end
    din[0] = 1'b0;
    tick(4);
    checks++; if (in_val[0] !== 1'b0) begin failures++; $display("FAIL sync_fall got=%b exp=0", in_val[0]); end
  endtask

  task automatic test_glitch_filter;
    int bad;
    filt_en[1] = 1'b1;
    tick(2);
    // 3-cycle pulse must be swallowed.
    din[1] = 1'b1;
    tick(3);
    din[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_val[1] !== 1'b0) bad++;
      tick(1);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL filt_short bad_cycles=%0d exp=0", bad); end
    // 5-cycle pulse passes, rising 2+4 cycles after the din edge.
    din[1] = 1'b1;
    tick(5);
    checks++; if (in_val[1] !== 1'b0) begin failures++; $display("FAIL filt_early got=%b exp=0", in_val[1]); end
    din[1] = 1'b0;
    tick(1);
    checks++; if (in_val[1] !== 1'b1) begin failures++; $display("FAIL filt_rise got=%b exp=1", in_val[1]); end
    tick(9);
    checks++; if (in_val[1] !== 1'b0) begin failures++; $display("FAIL filt_fall got=%b exp=0", in_val[1]); end
  endtask

  task automatic test_irq_modes;
    irq_mode = 16'h3900;     // pin2 rise, pin4 fall, pin5 both, pin6 level
    irq_en = 8'h34;
    tick(1);
    din = din | 8'h34;
    tick(5);
    checks++; if (irq_status !== 8'h24) begin failures++; $display("FAIL irq_rise got=%h exp=24", irq_status); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_or got=%b exp=1", irq); end
    irq_clr = 8'hFF; tick(1); irq_clr = 8'h00;
    checks++; if (irq_status !== 8'h00) begin failures++; $display("FAIL irq_clr got=%h exp=00", irq_status); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_or_clr got=%b exp=0", irq); end
    din = din & ~8'h34;
    tick(5);
    checks++; if (irq_status !== 8'h30) begin failures++; $display("FAIL irq_fall got=%h exp=30", irq_status); end
    irq_clr = 8'hFF; tick(1); irq_clr = 8'h00;
    // Clear lands on the same edge the rise event sets pin2.
    din[2] = 1'b1;
    tick(3);
    checks++; if (irq_status[2] !== 1'b0) begin failures++; $display("FAIL irq_pre_event got=%b exp=0", irq_status[2]); end
    irq_clr = 8'h04; tick(1); irq_clr = 8'h00;
    checks++; if (irq_status[2] !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", irq_status[2]); end
    irq_clr = 8'hFF; tick(1); irq_clr = 8'h00;
    // Level mode keeps re-setting; disabling the pin keeps the sticky bit.
    irq_en[6] = 1'b1; din[6] = 1'b1;
    tick(5);
    irq_clr = 8'h40; tick(1); irq_clr = 8'h00;
    checks++; if (irq_status !== 8'h40) begin failures++; $display("FAIL irq_level got=%h exp=40", irq_status); end
    irq_en[6] = 1'b0; din[6] = 1'b0;
    tick(5);
    checks++; if (irq_status !== 8'h40) begin failures++; $display("FAIL irq_en_off got=%h exp=40", irq_status); end
    irq_clr = 8'hFF; tick(1); irq_clr = 8'h00;
    checks++; if (irq_status !== 8'h00) begin failures++; $display("FAIL irq_clr2 got=%h exp=00", irq_status); end
  endtask

  task automatic test_ie_gating;
    in_en[7] = 1'b0; irq_en[7] = 1'b1;
    tick(1);
    din[7] = 1'b1;
    tick(6);
    checks++; if (in_val[7] !== 1'b0) begin failures++; $display("FAIL ie_off_val got=%b exp=0", in_val[7]); end
    checks++; if (irq_status[7] !== 1'b0) begin failures++; $display("FAIL ie_off_irq got=%b exp=0", irq_status[7]); end
    in_en[7] = 1'b1;
    tick(3);
    checks++; if (in_val[7] !== 1'b0) begin failures++; $display("FAIL ie_on_early got=%b exp=0", in_val[7]); end
    tick(1);
    checks++; if (in_val[7] !== 1'b1) begin failures++; $display("FAIL ie_on_val got=%b exp=1", in_val[7]); end
    tick(1);
    checks++; if (irq_status[7] !== 1'b1) begin failures++; $display("FAIL ie_on_irq got=%b exp=1", irq_status[7]); end
  endtask

  task automatic test_reset_mid;
    din[1] = 1'b1;           // pin1 still filtered: start a count
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (irq_status !== 8'h00) begin failures++; $display("FAIL mid_status got=%h exp=00", irq_status); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%b exp=0", irq); end
    checks++; if (oen !== 8'hFF) begin failures++; $display("FAIL mid_oen got=%h exp=ff", oen); end
    checks++; if (in_val !== 8'h00) begin failures++; $display("FAIL mid_in_val got=%h exp=00", in_val); end
    // Fresh count: ie edge, 2 sync edges, then 4 mismatch cycles.
    tick(6);
    checks++; if (in_val[1] !== 1'b0) begin failures++; $display("FAIL mid_refilt_early got=%b exp=0", in_val[1]); end
    tick(1);
    checks++; if (in_val[1] !== 1'b1) begin failures++; $display("FAIL mid_refilt got=%b exp=1", in_val[1]); end
  endtask

  initial begin
    test_reset();
    test_drive();
    test_sync_latency();
    test_glitch_filter();
    test_irq_modes();
    test_ie_gating();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
